// File: rtl/av_operand_loader_pkg.sv
// Shared precision encodings, default magnitude thresholds and loader state type
// for the attention/value operand loader.
package av_operand_loader_pkg;

  typedef enum logic [1:0] {
    PREC_INT4 = 2'b00,
    PREC_INT8 = 2'b01,
    PREC_FP16 = 2'b10
  } prec_e;

  localparam logic [15:0] DEF_THRESH_INT4 = 16'h0800;
  localparam logic [15:0] DEF_THRESH_INT8 = 16'h2000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_WAIT_DONE
  } loader_state_e;

endpackage

// File: rtl/av_operand_loader_prec_classifier.sv
// Per-token |a| max tracking and precision classification.
// AV_LOADER_FORCE_FP16_EN removes the tracking and always selects FP16.
module prec_classifier
  import av_operand_loader_pkg::*;
#(
  parameter int NUM_COLS   = 8,
  parameter int WIDTH_FP16 = 16,
  parameter int TOK_W      = 3,
  parameter logic [WIDTH_FP16-1:0] THRESH_INT4 = DEF_THRESH_INT4,
  parameter logic [WIDTH_FP16-1:0] THRESH_INT8 = DEF_THRESH_INT8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_i,
  input  logic                      first_i,
  input  logic                      last_i,
  input  logic [WIDTH_FP16-1:0]     data_i,
  input  logic [TOK_W-1:0]          tok_i,
  output logic [NUM_COLS-1:0][1:0]  precision_sel_o
);

  logic [NUM_COLS-1:0][1:0] precSel_q, precSel_d;

`ifdef AV_LOADER_FORCE_FP16_EN
  logic unusedOk;
  assign unusedOk = ^{data_i, first_i};

  always_comb begin
    precSel_d = precSel_q;
    if (sample_i && last_i) precSel_d[tok_i] = PREC_FP16;
  end
`else
  logic [WIDTH_FP16-1:0] mag, tokMax, runMax_q, runMax_d;

  always_comb begin
    mag = data_i;
    // The most negative code has no positive twin, so it saturates.
    if (data_i == {1'b1, {(WIDTH_FP16-1){1'b0}}}) mag = {1'b0, {(WIDTH_FP16-1){1'b1}}};
    else if (data_i[WIDTH_FP16-1]) mag = -data_i;
    tokMax = (first_i || (mag > runMax_q)) ? mag : runMax_q;
    runMax_d  = runMax_q;
    precSel_d = precSel_q;
    if (sample_i) begin
      runMax_d = tokMax;
      if (last_i) begin
        if (tokMax < THRESH_INT4)      precSel_d[tok_i] = PREC_INT4;
        else if (tokMax < THRESH_INT8) precSel_d[tok_i] = PREC_INT8;
        else                           precSel_d[tok_i] = PREC_FP16;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) runMax_q <= '0;
    else        runMax_q <= runMax_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) precSel_q <= {NUM_COLS{PREC_FP16}};
    else        precSel_q <= precSel_d;
  end

  assign precision_sel_o = precSel_q;

endmodule

// File: rtl/av_operand_loader.sv
// Streams one frame of attention/value beats into operand memories, then launches
// the multiplier. AV_LOADER_FORCE_FP16_EN pins every token's precision to FP16.
module av_operand_loader
  import av_operand_loader_pkg::*;
#(
  parameter int A_ROWS     = 8,
  parameter int V_COLS     = 32,
  parameter int NUM_COLS   = 8,
  parameter int WIDTH_FP16 = 16,
  parameter logic [WIDTH_FP16-1:0] THRESH_INT4 = DEF_THRESH_INT4,
  parameter logic [WIDTH_FP16-1:0] THRESH_INT8 = DEF_THRESH_INT8
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [WIDTH_FP16-1:0]                       in_data,
  input  logic                                        in_last,
  output logic [A_ROWS-1:0][NUM_COLS-1:0][WIDTH_FP16-1:0] a_mem,
  output logic [NUM_COLS-1:0][V_COLS-1:0][WIDTH_FP16-1:0] v_mem,
  output logic [NUM_COLS-1:0][1:0]                    precision_sel,
  output logic                                        start,
  input  logic                                        done,
  output logic                                        busy,
  output logic                                        frame_err
);

  localparam int ROW_W  = (A_ROWS > 1)   ? $clog2(A_ROWS)   : 1;
  localparam int ELEM_W = (V_COLS > 1)   ? $clog2(V_COLS)   : 1;
  localparam int TOK_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  loader_state_e state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ELEM_W-1:0] elem_q, elem_d;
  logic [TOK_W-1:0]  tok_q, tok_d;
  logic              inV_q, inV_d;
  logic              frameErr_q, frameErr_d;
  logic [A_ROWS-1:0][NUM_COLS-1:0][WIDTH_FP16-1:0] aMem_q, aMem_d;
  logic [NUM_COLS-1:0][V_COLS-1:0][WIDTH_FP16-1:0] vMem_q, vMem_d;

  logic accept, lastRow, lastElem, lastTok, finalBeat;

  assign in_ready  = rst_n && ((state_q == ST_IDLE) || (state_q == ST_FILL));
  assign accept    = in_valid && in_ready;
  assign lastRow   = (row_q  == ROW_W'(A_ROWS - 1));
  assign lastElem  = (elem_q == ELEM_W'(V_COLS - 1));
  assign lastTok   = (tok_q  == TOK_W'(NUM_COLS - 1));
  assign finalBeat = inV_q && lastElem && lastTok;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    elem_d     = elem_q;
    tok_d      = tok_q;
    inV_d      = inV_q;
    frameErr_d = 1'b0;
    aMem_d     = aMem_q;
    vMem_d     = vMem_q;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          if (inV_q) vMem_d[tok_q][elem_q] = in_data;
          else       aMem_d[row_q][tok_q]  = in_data;
          // A framing error or a completed frame both rewind to a[0][0].
          if ((in_last != finalBeat) || finalBeat) begin
            state_d    = (in_last != finalBeat) ? ST_IDLE : ST_ISSUE;
            frameErr_d = (in_last != finalBeat);
            row_d      = '0;
            elem_d     = '0;
            tok_d      = '0;
            inV_d      = 1'b0;
          end else begin
            state_d = ST_FILL;
            if (!inV_q) begin
              if (lastRow) begin
                inV_d = 1'b1;
                row_d = '0;
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end else if (lastElem) begin
              inV_d  = 1'b0;
              elem_d = '0;
              tok_d  = tok_q + TOK_W'(1);
            end else begin
              elem_d = elem_q + ELEM_W'(1);
            end
          end
        end
      end
      ST_ISSUE:     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      elem_q     <= '0;
      tok_q      <= '0;
      inV_q      <= 1'b0;
      frameErr_q <= 1'b0;
      aMem_q     <= '0;
      vMem_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      elem_q     <= elem_d;
      tok_q      <= tok_d;
      inV_q      <= inV_d;
      frameErr_q <= frameErr_d;
      aMem_q     <= aMem_d;
      vMem_q     <= vMem_d;
    end
  end

  prec_classifier #(
    .NUM_COLS   (NUM_COLS),
    .WIDTH_FP16 (WIDTH_FP16),
    .TOK_W      (TOK_W),
    .THRESH_INT4(THRESH_INT4),
    .THRESH_INT8(THRESH_INT8)
  ) u_classifier (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_i       (accept && !inV_q),
    .first_i        (row_q == '0),
    .last_i         (lastRow),
    .data_i         (in_data),
    .tok_i          (tok_q),
    .precision_sel_o(precision_sel)
  );

  assign a_mem     = aMem_q;
  assign v_mem     = vMem_q;
  assign start     = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = frameErr_q;

endmodule

// File: tb/tb_av_operand_loader.sv
// Self-checking bench for av_operand_loader: table-driven precision vectors,
// directed framing/reset sequences and randomized frames against a frame-level model.
module tb_av_operand_loader;
  import av_operand_loader_pkg::*;

  localparam int A     = 8;
  localparam int V     = 32;
  localparam int N     = 8;
  localparam int W     = 16;
  localparam int TOKB  = A + V;
  localparam int FRAME = N * TOKB;

`ifdef AV_LOADER_FORCE_FP16_EN
  localparam bit FORCED = 1'b1;
`else
  localparam bit FORCED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic done = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, start, busy, frame_err;
  logic [A-1:0][N-1:0][W-1:0] a_mem;
  logic [N-1:0][V-1:0][W-1:0] v_mem;
  logic [N-1:0][1:0] precision_sel;

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int errCount = 0;

  logic [W-1:0] frameData [FRAME];
  logic [W-1:0] expA [A][N];
  logic [W-1:0] expV [N][V];
  logic [1:0]   expSel [N];

  typedef struct {
    logic [W-1:0] peak;
    logic [1:0]   sel;
  } selVec_t;
  selVec_t selTable [N];

  av_operand_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .a_mem        (a_mem),
    .v_mem        (v_mem),
    .precision_sel(precision_sel),
    .start        (start),
    .done         (done),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start) startCount++;
    if (frame_err) errCount++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Frame-level model: place beats by index arithmetic, classify by peak magnitude.
  task automatic buildModel();
    int j, k, s, mag, peak;
    for (int b = 0; b < FRAME; b++) begin
      j = b / TOKB;
      k = b % TOKB;
      if (k < A) expA[k][j] = frameData[b];
      else       expV[j][k-A] = frameData[b];
    end
    for (int t = 0; t < N; t++) begin
      peak = 0;
      for (int r = 0; r < A; r++) begin
        s = int'($signed(expA[r][t]));
        mag = (s < 0) ? -s : s;
        if (mag > 32767) mag = 32767;
        if (mag > peak) peak = mag;
      end
      if (FORCED)              expSel[t] = 2'b10;
      else if (peak < 'h0800)  expSel[t] = 2'b00;
      else if (peak < 'h2000)  expSel[t] = 2'b01;
      else                     expSel[t] = 2'b10;
    end
  endtask

  task automatic clearModel();
    for (int r = 0; r < A; r++) for (int j = 0; j < N; j++) expA[r][j] = '0;
    for (int j = 0; j < N; j++) for (int e = 0; e < V; e++) expV[j][e] = '0;
    for (int j = 0; j < N; j++) expSel[j] = 2'b10;
  endtask

  function automatic int memMismatches();
    int n = 0;
    for (int r = 0; r < A; r++) for (int j = 0; j < N; j++) if (a_mem[r][j] !== expA[r][j]) n++;
    for (int j = 0; j < N; j++) for (int e = 0; e < V; e++) if (v_mem[j][e] !== expV[j][e]) n++;
    return n;
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic applyStimulus(input logic [W-1:0] d, input logic last, input bit gaps);
    int guard = 0;
    if (gaps) begin
      in_valid = 1'b0;
      while (($urandom_range(0, 1) == 1) && (guard < 8)) begin
        @(negedge clk);
        guard++;
      end
      guard = 0;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && (guard < 20)) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("in_ready wait", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic sendBeats(input int nBeats, input int lastAt, input bit gaps);
    for (int b = 0; b < nBeats; b++) applyStimulus(frameData[b], (b == lastAt), gaps);
  endtask

  task automatic checkResetState(input string tag);
    clearModel();
    checkOutput({tag, " in_ready"}, {31'b0, in_ready}, 32'd0);
    checkOutput({tag, " busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, " start"}, {31'b0, start}, 32'd0);
    checkOutput({tag, " frame_err"}, {31'b0, frame_err}, 32'd0);
    checkOutput({tag, " precision_sel"}, {16'b0, precision_sel}, 32'h0000_AAAA);
    checkOutput({tag, " mem nonzero"}, memMismatches(), 32'd0);
  endtask

  task automatic releaseDone(input string tag);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checkOutput({tag, " in_ready after done"}, {31'b0, in_ready}, 32'd1);
    checkOutput({tag, " busy after done"}, {31'b0, busy}, 32'd0);
  endtask

  // Full frame, then hold in WAIT_DONE with junk on the input to show nothing moves.
  task automatic completeFrame(input string tag, input bit gaps, input int hold, input bit doDone);
    int s0 = startCount;
    int readyCycles = 0;
    buildModel();
    sendBeats(FRAME, FRAME - 1, gaps);
    checkOutput({tag, " start in ISSUE"}, {31'b0, start}, 32'd1);
    checkOutput({tag, " busy in ISSUE"}, {31'b0, busy}, 32'd1);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (in_ready) readyCycles++;
    end
    in_valid = 1'b0;
    #1;
    checkOutput({tag, " in_ready while waiting"}, readyCycles, 32'd0);
    checkOutput({tag, " start pulses"}, startCount - s0, 32'd1);
    checkOutput({tag, " busy waiting"}, {31'b0, busy}, 32'd1);
    checkOutput({tag, " mem mismatches"}, memMismatches(), 32'd0);
    for (int j = 0; j < N; j++)
      checkOutput($sformatf("%s sel[%0d]", tag, j), {30'b0, precision_sel[j]}, {30'b0, expSel[j]});
    if (doDone) releaseDone(tag);
  endtask

  task automatic randomFrame();
    int cls;
    logic [W-1:0] m;
    for (int j = 0; j < N; j++) begin
      cls = $urandom_range(0, 3);
      for (int r = 0; r < A; r++) begin
        case (cls)
          0:       m = W'($urandom_range(0, 'h07FF));
          1:       m = W'($urandom_range(0, 'h1FFF));
          2:       m = W'($urandom_range(0, 'h7FFF));
          default: m = (r == 3) ? 16'h8000 : W'($urandom_range(0, 'h00FF));
        endcase
        frameData[j*TOKB + r] = ($urandom_range(0, 1) == 1) ? -m : m;
      end
      for (int e = 0; e < V; e++) frameData[j*TOKB + A + e] = W'($urandom_range(0, 'hFFFF));
    end
  endtask

  initial begin
    int s0, e0;

    selTable[0] = '{16'h0100, 2'b00};
    selTable[1] = '{16'h07FF, 2'b00};
    selTable[2] = '{16'h0800, 2'b01};
    selTable[3] = '{16'h1000, 2'b01};
    selTable[4] = '{16'h1FFF, 2'b01};
    selTable[5] = '{16'h8000, 2'b10};
    selTable[6] = '{16'hF801, 2'b00};
    selTable[7] = '{16'hE000, 2'b10};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("por");
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready after release", {31'b0, in_ready}, 32'd1);

    // Token 0 small, everything else large.
    for (int b = 0; b < FRAME; b++) frameData[b] = (b < A) ? 16'h0100 : 16'h4000;
    completeFrame("basic", 1'b0, 40, 1'b1);
    checkOutput("basic sel vector", {16'b0, precision_sel}, FORCED ? 32'h0000_AAAA : 32'h0000_AAA8);

    // Threshold boundaries, one peak per token.
    for (int j = 0; j < N; j++) begin
      for (int r = 0; r < A; r++) frameData[j*TOKB + r] = (r == j % A) ? selTable[j].peak : 16'h0010;
      for (int e = 0; e < V; e++) frameData[j*TOKB + A + e] = W'(j * 256 + e);
    end
    completeFrame("table", 1'b0, 2, 1'b1);
    for (int j = 0; j < N; j++)
      checkOutput($sformatf("table vec sel[%0d]", j), {30'b0, precision_sel[j]},
                  FORCED ? 32'd2 : {30'b0, selTable[j].sel});

    // Early in_last on beat 100, with done pulsed during FILL.
    randomFrame();
    s0 = startCount;
    e0 = errCount;
    done = 1'b1;
    sendBeats(50, -1, 1'b0);
    checkOutput("done ignored in FILL", {31'b0, busy}, 32'd1);
    done = 1'b0;
    for (int b = 50; b < 100; b++) applyStimulus(frameData[b], (b == 99), 1'b0);
    checkOutput("early last frame_err", {31'b0, frame_err}, 32'd1);
    checkOutput("early last busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("early last pulse width", {31'b0, frame_err}, 32'd0);
    checkOutput("early last err count", errCount - e0, 32'd1);
    checkOutput("early last no start", startCount - s0, 32'd0);

    // Missing in_last on the final beat.
    e0 = errCount;
    sendBeats(FRAME, -1, 1'b0);
    checkOutput("missing last frame_err", {31'b0, frame_err}, 32'd1);
    checkOutput("missing last in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("missing last no start", startCount - s0, 32'd0);
    checkOutput("missing last err count", errCount - e0, 32'd1);

    completeFrame("after err", 1'b0, 2, 1'b1);

    // Randomized frames with roughly half the cycles stalled.
    for (int f = 0; f < 2; f++) begin
      randomFrame();
      completeFrame($sformatf("rand%0d", f), 1'b1, 3, 1'b0);
      checkOutput($sformatf("rand%0d v_mem[7][31]", f), {16'b0, v_mem[7][31]}, {16'b0, frameData[FRAME-1]});
      checkOutput($sformatf("rand%0d a_mem[7][7]", f), {16'b0, a_mem[7][7]}, {16'b0, frameData[7*TOKB + 7]});
      releaseDone($sformatf("rand%0d", f));
    end

    // Reset part way through a frame.
    randomFrame();
    s0 = startCount;
    sendBeats(150, -1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState("mid rst");
    rst_n = 1'b1;
    #1;
    checkOutput("mid rst in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("mid rst no start", startCount - s0, 32'd0);

    // Reset while waiting for done.
    randomFrame();
    completeFrame("wait rst", 1'b0, 2, 1'b0);
    s0 = startCount;
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState("wait rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("wait rst no restart", startCount - s0, 32'd0);
    checkOutput("wait rst idle", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
